e203_dtcm_sram_ctrl: RTL

//  ICB-to-SRAM controller that drives the DTCM RAM macro wrapper (cs/we/addr/wem/din, dout).

---
 rtl/e203_dtcm_sram_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/e203_dtcm_sram_ctrl.sv
// ICB-to-SRAM controller for the DTCM macro: 1-cycle read latency, stall-safe read data,
// out-of-range error flagging, optional idle light-sleep (define E203_DTCM_AUTO_LS_EN).
module e203_dtcm_sram_ctrl #(
    parameter int unsigned DW          = 32,
    parameter int unsigned MW          = 4,
    parameter int unsigned AW          = 10,
    parameter int unsigned DP          = 1024,
    parameter int unsigned LS_IDLE_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,

    input  logic          icb_cmd_valid,
    output logic          icb_cmd_ready,
    input  logic [31:0]   icb_cmd_addr,
    input  logic          icb_cmd_read,
    input  logic [DW-1:0] icb_cmd_wdata,
    input  logic [MW-1:0] icb_cmd_wmask,

    output logic          icb_rsp_valid,
    input  logic          icb_rsp_ready,
    output logic [DW-1:0] icb_rsp_rdata,
    output logic          icb_rsp_err,

    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [MW-1:0] ram_wem,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_ls,
    output logic          ram_ds,
    output logic          ram_sd
);

    logic [AW-1:0] word_idx;
    logic          oor;
    logic          accept;
    logic          wake_block;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rd_q, rd_d;
    logic          err_q, err_d;
    logic          first_q, first_d;
    logic [DW-1:0] holdup_q, holdup_d;

    logic          unused_addr_lsb;
    assign unused_addr_lsb = ^icb_cmd_addr[1:0];

    assign word_idx = icb_cmd_addr[AW+1:2];
    assign oor      = (|icb_cmd_addr[31:AW+2]) | (32'(word_idx) >= DP);

    assign icb_cmd_ready = (~rsp_valid_q | icb_rsp_ready) & ~wake_block;
    assign accept        = icb_cmd_valid & icb_cmd_ready;

    assign ram_cs   = accept & ~oor;
    assign ram_we   = ~icb_cmd_read;
    assign ram_addr = word_idx;
    assign ram_wem  = icb_cmd_read ? '0 : icb_cmd_wmask;
    assign ram_din  = icb_cmd_wdata;
    assign ram_ds   = 1'b0;
    assign ram_sd   = 1'b0;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rd_d        = rd_q;
        err_d       = err_q;
        first_d     = first_q;
        holdup_d    = holdup_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rd_d        = icb_cmd_read;
            err_d       = oor;
            first_d     = 1'b1;
        end else if (rsp_valid_q & icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else if (rsp_valid_q) begin
            // The macro output is only trustworthy in the first response cycle.
            first_d = 1'b0;
            if (first_q) begin
                holdup_d = ram_dout;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            first_q     <= 1'b0;
            holdup_q    <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            first_q     <= first_d;
            holdup_q    <= holdup_d;
        end
    end

    assign icb_rsp_valid = rsp_valid_q;
    assign icb_rsp_err   = rsp_valid_q & err_q;
    assign icb_rsp_rdata = (rsp_valid_q & rd_q & ~err_q) ? (first_q ? ram_dout : holdup_q) : '0;

`ifdef E203_DTCM_AUTO_LS_EN
    localparam int unsigned CntW = $clog2(LS_IDLE_CYC + 1);

    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic            ls_q, ls_d;

    always_comb begin
        idle_cnt_d = '0;
        if (~icb_cmd_valid & ~rsp_valid_q) begin
            idle_cnt_d = (idle_cnt_q == CntW'(LS_IDLE_CYC)) ? idle_cnt_q : idle_cnt_q + 1'b1;
        end
        // A pending command clears the count, so sleep drops on the following edge.
        ls_d = (idle_cnt_d == CntW'(LS_IDLE_CYC));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
            ls_q       <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            ls_q       <= ls_d;
        end
    end

    assign wake_block = ls_q;
    assign ram_ls     = ls_q;
`else
    logic unused_ls_cfg;
    assign unused_ls_cfg = (LS_IDLE_CYC == 0);
    assign wake_block    = 1'b0;
    assign ram_ls        = 1'b0;
`endif

endmodule
